// File: rtl/cpu_types_pkg.sv
// Shared pipeline-control types: controller state, register index, strobe bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        HALT_DRAIN = 2'd2,
        HALTED     = 2'd3
    } pipe_state_t;

    localparam int REG_W = 5;
    typedef logic [REG_W-1:0] regbits_t;

    // One bundle for every strobe the controller drives into the datapath.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } pipe_ctrl_t;

    // The strobe patterns, in field order:
    // {pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl}.
    localparam pipe_ctrl_t CTRL_IDLE       = pipe_ctrl_t'(8'b0_0000_000);
    localparam pipe_ctrl_t CTRL_RUN        = pipe_ctrl_t'(8'b1_1111_000);
    localparam pipe_ctrl_t CTRL_BRANCH     = pipe_ctrl_t'(8'b1_1111_110);
    localparam pipe_ctrl_t CTRL_LOAD_USE   = pipe_ctrl_t'(8'b0_0111_010);
    localparam pipe_ctrl_t CTRL_JUMP       = pipe_ctrl_t'(8'b1_1111_100);
    localparam pipe_ctrl_t CTRL_FETCH_MISS = pipe_ctrl_t'(8'b0_1111_100);
    localparam pipe_ctrl_t CTRL_HALT       = pipe_ctrl_t'(8'b0_0001_111);
    localparam pipe_ctrl_t CTRL_DRAIN      = pipe_ctrl_t'(8'b0_0001_000);

endpackage

// File: rtl/pipeline_control_if.sv
// Bundle of the controller's hazard inputs and latch strobes.
// Latency: n/a (wires only).
// Backpressure: n/a.
// Ports: none; signals mirror pipeline_controller, ctrl/tb modports give direction.
interface pipeline_control_if #(
    parameter int CNT_W = 16
);
    import cpu_types_pkg::*;

    logic             ihit;
    logic             dhit;
    logic             mem_req;
    logic             idex_memRd;
    regbits_t         idex_wsel;
    regbits_t         ifid_rs;
    regbits_t         ifid_rt;
    logic             branch_taken;
    logic             jump;
    logic             halt_mem;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             halt;
    logic [CNT_W-1:0] stall_count;

    modport ctrl (
        input  ihit, dhit, mem_req, idex_memRd, idex_wsel, ifid_rs, ifid_rt,
               branch_taken, jump, halt_mem,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halt, stall_count
    );

    modport tb (
        output ihit, dhit, mem_req, idex_memRd, idex_wsel, ifid_rs, ifid_rt,
               branch_taken, jump, halt_mem,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halt, stall_count
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: flags a load in EX whose destination feeds the ID instruction.
// Latency: combinational, 0 cycles.
// Backpressure: none; result is consumed by the controller the same cycle.
// Ports: idex_memRd_i/idex_wsel_i (EX load), ifid_rs_i/ifid_rt_i (ID sources), lu_stall_o.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     idex_memRd_i,
    input  regbits_t idex_wsel_i,
    input  regbits_t ifid_rs_i,
    input  regbits_t ifid_rt_i,
    output logic     lu_stall_o
);

    // $zero is never written, so a load targeting it cannot create a hazard.
    assign lu_stall_o = idex_memRd_i
                     && (idex_wsel_i != '0)
                     && ((idex_wsel_i == ifid_rs_i) || (idex_wsel_i == ifid_rt_i));

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush scheduler for the 5-stage pipeline: latch enables, flushes, PC enable, halt drain.
// Latency: strobes are Mealy (same cycle as inputs); halt/stall_count registered, halt DRAIN_CYCLES+1 edges after halt_mem.
// Backpressure: dcache miss freezes every latch; icache miss holds the PC and injects bubbles.
// Ports: CLK/RST; ihit, dhit, mem_req, load-use fields, branch_taken, jump, halt_mem in;
//        pc_en, four latch enables, three flushes, halt, stall_count out.
module pipeline_controller
    import cpu_types_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_req,
    input  logic             idex_memRd,
    input  regbits_t         idex_wsel,
    input  regbits_t         ifid_rs,
    input  regbits_t         ifid_rt,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_count
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    pipe_state_t        state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               halt_q, halt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    pipe_ctrl_t         ctrl;
    pipe_ctrl_t         ctrl_out;
    logic               run_rules;
    logic               lu_stall;

    hazard_detect u_hazard_detect (
        .idex_memRd_i (idex_memRd),
        .idex_wsel_i  (idex_wsel),
        .ifid_rs_i    (ifid_rs),
        .ifid_rt_i    (ifid_rt),
        .lu_stall_o   (lu_stall)
    );

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        ctrl      = CTRL_IDLE;
        run_rules = 1'b0;

        unique case (state_q)
            RUN: begin
                if (halt_mem) begin
                    ctrl    = CTRL_HALT;
                    state_d = HALT_DRAIN;
                    drain_d = DRAIN_W'(DRAIN_CYCLES);
                end else if (mem_req && !dhit) begin
                    state_d = MEM_WAIT;
                end else begin
                    run_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                // EX stayed frozen during the wait, so the branch/hazard
                // inputs seen on the dhit cycle are still the live ones.
                if (dhit) begin
                    state_d   = RUN;
                    run_rules = 1'b1;
                end
            end
            HALT_DRAIN: begin
                ctrl    = CTRL_DRAIN;
                drain_d = (drain_q == '0) ? '0 : drain_q - 1'b1;
                if (drain_d == '0) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                ctrl = CTRL_IDLE;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Remaining priority chain shared by RUN and the MEM_WAIT exit cycle.
        if (run_rules) begin
            if (branch_taken) begin
                ctrl = CTRL_BRANCH;
            end else if (lu_stall) begin
                ctrl = CTRL_LOAD_USE;
            end else if (jump && ihit) begin
                ctrl = CTRL_JUMP;
            end else if (!ihit) begin
                ctrl = CTRL_FETCH_MISS;
            end else begin
                ctrl = CTRL_RUN;
            end
        end
    end

    // Strobes are forced low for as long as reset is held, not just after the edge.
    assign ctrl_out = RST ? CTRL_IDLE : ctrl;

    assign pc_en       = ctrl_out.pc_en;
    assign ifid_en     = ctrl_out.ifid_en;
    assign idex_en     = ctrl_out.idex_en;
    assign exmem_en    = ctrl_out.exmem_en;
    assign memwb_en    = ctrl_out.memwb_en;
    assign ifid_flush  = ctrl_out.ifid_flush;
    assign idex_flush  = ctrl_out.idex_flush;
    assign exmem_flush = ctrl_out.exmem_flush;

    // halt rises on the same edge that enters HALTED and never clears.
    assign halt_d = halt_q || (state_d == HALTED);

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q != HALTED) && !ctrl.pc_en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            drain_q <= '0;
            halt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            halt_q  <= halt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign halt        = halt_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller (CNT_W=4 so saturation is reachable).
// Latency: strobes checked on the negedge of the cycle that drove them.
// Backpressure: n/a.
module tb_pipeline_controller;

    typedef struct packed {
        logic       ihit;
        logic       dhit;
        logic       mem_req;
        logic       memrd;
        logic [4:0] wsel;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic       jmp;
        logic       hm;
    } stim_t;

    // Expected vector: {pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, halt}
    localparam logic [8:0] X_ZERO   = 9'b0_0000_000_0;
    localparam logic [8:0] X_RUN    = 9'b1_1111_000_0;
    localparam logic [8:0] X_LU     = 9'b0_0111_010_0;
    localparam logic [8:0] X_BR     = 9'b1_1111_110_0;
    localparam logic [8:0] X_JMP    = 9'b1_1111_100_0;
    localparam logic [8:0] X_MISS   = 9'b0_1111_100_0;
    localparam logic [8:0] X_HALT   = 9'b0_0001_111_0;
    localparam logic [8:0] X_DRAIN  = 9'b0_0001_000_0;
    localparam logic [8:0] X_HALTED = 9'b0_0000_000_1;

    logic clk;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;
    logic [8:0] sb[$];

    pipeline_control_if #(.CNT_W(4)) pif ();

    pipeline_controller #(.DRAIN_CYCLES(2), .CNT_W(4)) dut (
        .CLK          (clk),
        .RST          (rst),
        .ihit         (pif.ihit),
        .dhit         (pif.dhit),
        .mem_req      (pif.mem_req),
        .idex_memRd   (pif.idex_memRd),
        .idex_wsel    (pif.idex_wsel),
        .ifid_rs      (pif.ifid_rs),
        .ifid_rt      (pif.ifid_rt),
        .branch_taken (pif.branch_taken),
        .jump         (pif.jump),
        .halt_mem     (pif.halt_mem),
        .pc_en        (pif.pc_en),
        .ifid_en      (pif.ifid_en),
        .idex_en      (pif.idex_en),
        .exmem_en     (pif.exmem_en),
        .memwb_en     (pif.memwb_en),
        .ifid_flush   (pif.ifid_flush),
        .idex_flush   (pif.idex_flush),
        .exmem_flush  (pif.exmem_flush),
        .halt         (pif.halt),
        .stall_count  (pif.stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t st(input logic ihit, input logic dhit, input logic mreq,
                                 input logic memrd, input logic [4:0] wsel,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic br, input logic jmp, input logic hm);
        stim_t s;
        s.ihit = ihit; s.dhit = dhit; s.mem_req = mreq; s.memrd = memrd;
        s.wsel = wsel; s.rs = rs; s.rt = rt; s.br = br; s.jmp = jmp; s.hm = hm;
        return s;
    endfunction

    function automatic logic [8:0] obs();
        return {pif.pc_en, pif.ifid_en, pif.idex_en, pif.exmem_en, pif.memwb_en,
                pif.ifid_flush, pif.idex_flush, pif.exmem_flush, pif.halt};
    endfunction

    task automatic set_inputs(input stim_t s);
        pif.ihit         = s.ihit;
        pif.dhit         = s.dhit;
        pif.mem_req      = s.mem_req;
        pif.idex_memRd   = s.memrd;
        pif.idex_wsel    = s.wsel;
        pif.ifid_rs      = s.rs;
        pif.ifid_rt      = s.rt;
        pif.branch_taken = s.br;
        pif.jump         = s.jmp;
        pif.halt_mem     = s.hm;
    endtask

    // Drive one cycle of stimulus and queue the strobes it must produce.
    task automatic drive(input stim_t s, input logic [8:0] x);
        @(posedge clk);
        #1;
        set_inputs(s);
        sb.push_back(x);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_inputs(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] got;
        rst = 1'b1;
        // Inputs that would normally produce a branch pattern must be masked.
        set_inputs(st(1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        repeat (2) @(negedge clk);
        got = obs();
        tests_run++;
        if (got !== X_ZERO) begin
            tests_failed++;
            $display("FAIL reset_strobes: got %b want %b", got, X_ZERO);
        end
        tests_run++;
        if (pif.stall_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_count: got %0d want 0", pif.stall_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        stim_t s[$];
        logic [8:0] x[$];
        logic [8:0] e;
        do_reset();
        s.push_back(st(1, 0, 0, 1, 5, 5, 0, 0, 0, 0)); x.push_back(X_LU);   // rs match
        s.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(X_RUN);
        s.push_back(st(1, 0, 0, 1, 9, 1, 9, 0, 0, 0)); x.push_back(X_LU);   // rt match
        s.push_back(st(1, 0, 0, 1, 0, 0, 0, 0, 0, 0)); x.push_back(X_RUN);  // $zero never hazards
        s.push_back(st(1, 0, 0, 0, 7, 7, 7, 0, 0, 0)); x.push_back(X_RUN);  // not a load
        foreach (s[i]) begin
            drive(s[i], x[i]);
            @(negedge clk);
            e = sb.pop_front();
            tests_run++;
            if (obs() !== e) begin
                tests_failed++;
                $display("FAIL load_use[%0d]: got %b want %b", i, obs(), e);
            end
            if (i == 1) begin
                tests_run++;
                if (pif.stall_count !== 4'd1) begin
                    tests_failed++;
                    $display("FAIL load_use_count: got %0d want 1", pif.stall_count);
                end
            end
        end
        tests_run++;
        if (pif.stall_count !== 4'd2) begin
            tests_failed++;
            $display("FAIL load_use_count_end: got %0d want 2", pif.stall_count);
        end
    endtask

    task automatic test_priority();
        stim_t s[$];
        logic [8:0] x[$];
        logic [8:0] e;
        do_reset();
        s.push_back(st(1, 0, 0, 1, 5, 5, 0, 1, 0, 0)); x.push_back(X_BR);   // branch beats load-use
        s.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 1, 0)); x.push_back(X_JMP);
        s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); x.push_back(X_MISS); // jump waits for ihit
        s.push_back(st(1, 0, 0, 1, 3, 3, 0, 0, 1, 0)); x.push_back(X_LU);   // load-use beats jump
        s.push_back(st(1, 1, 1, 0, 0, 0, 0, 0, 0, 0)); x.push_back(X_RUN);  // mem hit, no wait
        s.push_back(st(1, 0, 1, 0, 0, 0, 0, 1, 0, 1)); x.push_back(X_HALT); // halt beats everything
        foreach (s[i]) begin
            drive(s[i], x[i]);
            @(negedge clk);
            e = sb.pop_front();
            tests_run++;
            if (obs() !== e) begin
                tests_failed++;
                $display("FAIL priority[%0d]: got %b want %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_mem_wait();
        stim_t s[$];
        logic [8:0] x[$];
        logic [8:0] e;
        do_reset();
        s.push_back(st(1, 0, 1, 0, 0, 0, 0, 0, 0, 0)); x.push_back(X_ZERO);
        s.push_back(st(1, 0, 1, 0, 0, 0, 0, 0, 0, 0)); x.push_back(X_ZERO);
        s.push_back(st(1, 0, 1, 0, 0, 0, 0, 0, 0, 0)); x.push_back(X_ZERO);
        s.push_back(st(1, 1, 1, 0, 0, 0, 0, 0, 0, 0)); x.push_back(X_RUN);
        s.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(X_RUN);  // proves state is RUN
        s.push_back(st(1, 0, 1, 0, 0, 0, 0, 1, 0, 0)); x.push_back(X_ZERO); // wait beats branch
        s.push_back(st(1, 1, 1, 0, 0, 0, 0, 1, 0, 0)); x.push_back(X_BR);   // branch re-evaluated
        foreach (s[i]) begin
            drive(s[i], x[i]);
            @(negedge clk);
            e = sb.pop_front();
            tests_run++;
            if (obs() !== e) begin
                tests_failed++;
                $display("FAIL mem_wait[%0d]: got %b want %b", i, obs(), e);
            end
            if (i == 3) begin
                tests_run++;
                if (pif.stall_count !== 4'd3) begin
                    tests_failed++;
                    $display("FAIL mem_wait_count: got %0d want 3", pif.stall_count);
                end
            end
        end
    endtask

    task automatic test_halt_drain();
        logic [8:0] e;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            // Live RUN-style inputs after the pulse must be ignored.
            if (i == 0)      drive(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 1), X_HALT);
            else if (i < 3)  drive(st(1, 0, 1, 0, 0, 0, 0, 1, 0, 0), X_DRAIN);
            else             drive(st(1, 1, 0, 0, 0, 0, 0, 1, 1, 0), X_HALTED);
            @(negedge clk);
            e = sb.pop_front();
            tests_run++;
            if (obs() !== e) begin
                tests_failed++;
                $display("FAIL halt_drain[%0d]: got %b want %b", i, obs(), e);
            end
        end
        tests_run++;
        if (pif.stall_count !== 4'd3) begin
            tests_failed++;
            $display("FAIL halt_count: got %0d want 3", pif.stall_count);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [8:0] e;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(st(1, 0, 1, 0, 0, 0, 0, 0, 0, 0), X_ZERO);
            @(negedge clk);
            e = sb.pop_front();
            tests_run++;
            if (obs() !== e) begin
                tests_failed++;
                $display("FAIL rst_wait_enter[%0d]: got %b want %b", i, obs(), e);
            end
        end
        tests_run++;
        if (pif.stall_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL rst_wait_pre_count: got %0d want 1", pif.stall_count);
        end
        #1;
        set_inputs(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if (obs() !== X_ZERO || pif.stall_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL rst_wait_async: got %b cnt %0d want %b cnt 0", obs(), pif.stall_count, X_ZERO);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (obs() !== X_RUN) begin
            tests_failed++;
            $display("FAIL rst_wait_release: got %b want %b", obs(), X_RUN);
        end
        drive(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), X_RUN);
        @(negedge clk);
        e = sb.pop_front();
        tests_run++;
        if (obs() !== e || pif.stall_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL rst_wait_after: got %b cnt %0d want %b cnt 0", obs(), pif.stall_count, e);
        end
    endtask

    task automatic test_saturation();
        logic [8:0] e;
        logic [3:0] want;
        do_reset();
        for (int i = 0; i < 21; i++) begin
            drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), X_MISS);
            @(negedge clk);
            e = sb.pop_front();
            want = (i > 15) ? 4'd15 : 4'(i);
            tests_run++;
            if (obs() !== e || pif.stall_count !== want) begin
                tests_failed++;
                $display("FAIL saturation[%0d]: got %b cnt %0d want %b cnt %0d",
                         i, obs(), pif.stall_count, e, want);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_inputs(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_load_use();
        test_priority();
        test_mem_wait();
        test_halt_drain();
        test_reset_mid_wait();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central stall/flush scheduler for the five-stage MIPS pipeline. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB latches by generating per-latch enable and flush strobes and the PC enable. Inputs are cache handshakes (`ihit`, `dhit`), load-use hazard fields, branch/jump resolution and halt. It owns the memory-wait and halt-drain state machine, plus a stall-cycle performance counter. It sits beside the datapath and drives the enable/flush inputs of every pipeline-register interface.

## Interface
- `DRAIN_CYCLES`, default 2: cycles between halt entering MEM/WB and `halt` assertion, so the final writeback completes.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `CLK`  in  1: sole clock, rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `ihit`  in  1: instruction fetch completed this cycle.
- `dhit`  in  1: data access completed this cycle.
- `mem_req`  in  1: instruction in MEM issues dREN or dWEN.
- `idex_memRd`  in  1: instruction in EX is a load.
- `idex_wsel`  in  5: destination register of the EX instruction.
- `ifid_rs`, `ifid_rt`  in  5 each: source registers of the ID instruction.
- `branch_taken`  in  1: branch resolved taken in EX.
- `jump`  in  1: J/JAL/JR decoded in ID.
- `halt_mem`  in  1: halt instruction at the EX/MEM output, entering MEM/WB.
- `pc_en`  out  1: PC load enable.
- `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each: latch enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`  out  1 each: load a bubble (all control zero) on the next edge.
- `halt`  out  1: sticky processor halted, registered.
- `stall_count`  out  CNT_W: cycles with `pc_en`=0 while not halted, registered.

## Operation
States: RUN, MEM_WAIT, HALT_DRAIN, HALTED. Reset enters RUN.

**RUN.** Conditions are evaluated in the priority order listed; the first match wins.
1. **Halt:** `halt_mem`=1.
   - `memwb_en`=1, `exmem_flush`=1, `idex_flush`=1, `ifid_flush`=1, `pc_en`=0.
   - Next state HALT_DRAIN; drain counter loads `DRAIN_CYCLES`.
2. **Memory wait:** `mem_req`=1 and `dhit`=0.
   - All enables 0, `pc_en`=0.
   - Next state MEM_WAIT.
3. **Branch taken:** `branch_taken`=1.
   - All enables 1, `pc_en`=1 (target loaded), `ifid_flush`=1, `idex_flush`=1.
   - Squashes any coincident load-use or jump.
4. **Load-use:** `idex_memRd`=1, `idex_wsel`≠0, and `idex_wsel` equals `ifid_rs` or `ifid_rt`.
   - `pc_en`=0, `ifid_en`=0, `idex_flush`=1; EX/MEM and MEM/WB advance.
5. **Jump:** `jump`=1 with `ihit`=1.
   - All enables 1, `pc_en`=1, `ifid_flush`=1.
6. **Fetch miss:** `ihit`=0.
   - `pc_en`=0, `ifid_flush`=1; downstream latches advance.
7. **Otherwise:** all enables 1, `pc_en`=1, no flushes.

**MEM_WAIT.**
- While `dhit`=0: all enables 0, `pc_en`=0.
- On `dhit`=1: apply RUN rules 3–7 this cycle and return to RUN.

**HALT_DRAIN.**
- All enables 0 except `memwb_en`=1, which holds the halt in WB; flushes 0, `pc_en`=0.
- The counter decrements each cycle; at 0 the next state is HALTED.

**HALTED.**
- All enables 0, all flushes 0, `pc_en`=0, `halt`=1.
- Exited only by `RST`.

**Stall counter.**
- `stall_count` increments when state≠HALTED and `pc_en`=0.
- Saturates at all-ones; no wrap.

## Timing
- Enables, flushes and `pc_en` are combinational (Mealy) from state and current inputs and take effect at the next `CLK` edge.
- `halt` and `stall_count` are registered.
- **Reset:** while `RST`=1, all enables, flushes and `pc_en` are 0; `halt`=0, `stall_count`=0, state RUN.
- **Reset mid-operation:** reset asserted in any state, including MEM_WAIT or HALT_DRAIN, returns to RUN immediately (asynchronous); no pending work survives.
- **Load-use:** costs exactly 1 bubble cycle.
- **Branch:** costs 2 squashed slots.
- **Halt latency:** `halt` rises `DRAIN_CYCLES`+1 edges after the cycle `halt_mem`=1 is seen.
- **Simultaneous `dhit`=0 and `branch_taken`:** memory wait wins. The branch is re-evaluated on the `dhit` cycle because EX is frozen.
- **`idex_wsel`=0:** never a hazard.

## Structure
- `pipe_state_t` (2-bit enum) and `regbits_t` belong in `cpu_types_pkg`.
- New interface `pipeline_control_if` with modports for the controller and the tb.
- One sub-module: `hazard_detect`, the combinational load-use comparator producing `lu_stall`.

## Test plan
- **Load-use:** `idex_memRd`=1, `idex_wsel`=5, `ifid_rs`=5, `ihit`=1 -> that cycle `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `exmem_en`=1; `stall_count` goes 0→1.
- **Memory wait:** `mem_req`=1, `dhit`=0 for 3 cycles, then 1 -> all enables 0 for 3 cycles, all 1 on the `dhit` cycle, state back to RUN; `stall_count`=3.
- **Branch beats load-use:** `branch_taken`=1 together with a load-use match -> `pc_en`=1, `ifid_flush`=`idex_flush`=1.
- **Halt drain:** `halt_mem`=1 pulse -> `halt`=0 for 3 edges, then 1 and stays 1; all enables 0 afterward.
- **Reset mid-wait:** in MEM_WAIT, `RST` pulses asynchronously mid-cycle -> outputs 0 immediately, `stall_count`=0, RUN after release.
- **Saturation:** `CNT_W`=4, `ihit` held 0 for 20 cycles -> `stall_count`=15, with no wrap.
